soc_sysid_ext: RTL and testbench
================================

Name: soc_sysid_ext

Overview:
Parametrised system-ID and uptime peripheral on the SoC Avalon-MM interconnect, extending the basic ID/timestamp slave. Provides read-only ID, build timestamp and capability words, a prescaled 64-bit uptime counter with coherent two-word readout, control and status registers, and byte-writable scratch registers. Software uses it to identify the hardware build and to timestamp events.

Parameters:
SYSTEM_ID, 32'h0000_0000, value returned at word 0
TIMESTAMP, 1642576140, build timestamp returned at word 1
NUM_SCRATCH, 4, number of 32-bit scratch registers, legal range 1..8
TICK_DIV, 50, clock cycles per uptime increment, legal range 1..65535
ADDR_W, 4, word-address width, fixed at 4

Ports:
clock  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
address  in  ADDR_W  word address
read  in  1  read strobe, one cycle per access
write  in  1  write strobe, one cycle per access
writedata  in  32  write data
byteenable  in  4  byte lanes; used only by scratch registers
readdata  out  32  registered read data
readdatavalid  out  1  high for one cycle, one cycle after read

Behaviour:
- Reset (reset_n low at a clock edge): readdata=0, readdatavalid=0, uptime=0, prescaler=0, hi_shadow=0, CTRL.EN=1, STATUS.OVF=0, all scratch=0. Reset mid-operation discards any pending read: readdatavalid=0 on the following cycle.
- Read latency is fixed at 1. When read is high at edge N, readdata and readdatavalid=1 are valid after edge N. readdatavalid is otherwise 0. readdata holds its last value when no read is in progress. No wait states.
- Address map (word):
  - 0 ID: SYSTEM_ID, read-only.
  - 1 TIMESTAMP: read-only.
  - 2 CAPS: [7:0]=NUM_SCRATCH, [23:8]=TICK_DIV, [31:24]=8'h02 (generation), read-only.
  - 3 CTRL: bit0 EN (R/W). bit1 CLR is write-only, self-clearing, and reads as 0. Other bits read as 0.
  - 4 STATUS: bit0 OVF is sticky; writing 1 clears it. Other bits read as 0.
  - 5 UPTIME_LO: reading returns uptime[31:0] and, in the same edge, copies uptime[63:32] into hi_shadow.
  - 6 UPTIME_HI: returns hi_shadow. This gives a coherent 64-bit value when software reads LO then HI.
  - 8..8+NUM_SCRATCH-1 SCRATCH: R/W, with per-byte write gated by byteenable.
  - All other addresses read 0. Writes to them have no effect.
- Writes to read-only words are ignored. byteenable is ignored outside the scratch registers.
- If read and write target the same word in the same cycle, the read returns the pre-write value and the write takes effect.
- Prescaler:
  - When EN=1, the prescaler counts 0..TICK_DIV-1. A tick occurs on the edge where prescaler==TICK_DIV-1, and the prescaler then wraps to 0.
  - TICK_DIV=1 produces a tick every cycle.
  - When EN=0, prescaler and uptime both hold.
- Uptime: increments by 1 on each tick. At 2^64-1 it wraps to 0 and sets OVF.
- CLR write (writedata[1]=1 to CTRL): on that edge, uptime=0 and prescaler=0. The EN value in the same write is also applied. CLR has priority over a same-edge tick, so no increment occurs. OVF is unaffected by CLR.
- Same-edge OVF set (wrap) and OVF clear write: set wins.
- Reading UPTIME_LO on a tick edge returns the pre-increment value. The shadow captures the pre-increment high word, so the pair stays coherent.

Decomposition:
- Package soc_sysid_pkg holds:
  - register word-offset constants (REG_ID..REG_SCRATCH0)
  - CTRL/STATUS bit-index constants
  - the CAPS generation constant 8'h02
- One sub-module: soc_sysid_uptime. It contains the prescaler, the 64-bit counter, the wrap/overflow pulse, and the clear/enable inputs.
- The top level holds register decode, the shadow register, the scratch array and the read pipeline.

Test Plan:
- Reset, then read words 0, 1 and 2 (defaults) -> readdata 0x00000000, 1642576140, 0x02003204, each with readdatavalid exactly one cycle after read.
- TICK_DIV=4, EN=1 from reset, 40 cycles elapse, then read LO then HI -> LO=10, HI=0. Write CTRL=0 (EN off), wait 20 cycles -> LO still 10.
- Preload uptime to 0x00000000_FFFFFFFF via a bench-side force, with the tick landing between the LO and HI reads -> LO=0xFFFFFFFF, HI=0 (coherent, not 1).
- Force uptime to 2^64-1, one tick -> uptime=0 and STATUS=1. Write STATUS=1 on the same edge as a second wrap -> STATUS stays 1. A later write of 1 -> STATUS=0.
- Write SCRATCH0=0xA5A5A5A5 with be=4'b1111, then write 0x12345678 with be=4'b0101 -> read returns 0xA534A578. A write to word 0 leaves ID unchanged. A read of word 15 returns 0.
- Write CTRL=0x3 on a tick edge -> uptime=0 and prescaler=0 next cycle, EN=1, no increment that edge. Assert reset_n low on the cycle after a read -> readdatavalid=0 and all registers at reset values.

Source files
------------

// File: rtl/soc_sysid_pkg.sv
// Shared constants for the system-ID / uptime peripheral: word offsets,
// CTRL/STATUS bit positions and the CAPS generation code.
package soc_sysid_pkg;

  localparam logic [3:0] REG_ID        = 4'd0;
  localparam logic [3:0] REG_TIMESTAMP = 4'd1;
  localparam logic [3:0] REG_CAPS      = 4'd2;
  localparam logic [3:0] REG_CTRL      = 4'd3;
  localparam logic [3:0] REG_STATUS    = 4'd4;
  localparam logic [3:0] REG_UPTIME_LO = 4'd5;
  localparam logic [3:0] REG_UPTIME_HI = 4'd6;
  localparam logic [3:0] REG_SCRATCH0  = 4'd8;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int STATUS_OVF_BIT = 0;

  localparam logic [7:0] CAPS_GEN = 8'h02;

endpackage

// File: rtl/soc_sysid_uptime.sv
// Prescaled 64-bit uptime counter. A tick fires on the edge where the
// prescaler sits at TICK_DIV-1; clear beats a same-edge tick, and wrap_o
// pulses combinationally on the edge where the counter rolls over.
module soc_sysid_uptime #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en_i,
  input  logic        clr_i,
  output logic [63:0] uptime_o,
  output logic        wrap_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   cnt_q, cnt_d;
  logic          tick;

  assign uptime_o = cnt_q;

  // Next-state for prescaler and counter; clear overrides any tick.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    wrap_o  = 1'b0;
    tick    = en_i && (presc_q == PRESC_LAST);
    if (clr_i) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = cnt_q + 64'd1;
      wrap_o  = &cnt_q;
    end else if (en_i) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/soc_sysid_ext.sv
// System-ID and uptime slave on the Avalon-MM interconnect: read-only
// identification words, CTRL/STATUS, a coherent LO/HI uptime readout via a
// high-word shadow, byte-writable scratch registers and a 1-cycle read pipe.
module soc_sysid_ext
  import soc_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd1642576140,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned TICK_DIV    = 50,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  logic        ctrl_en_q, ctrl_en_d;
  logic        ovf_q, ovf_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];
  logic [31:0] readdata_q, readdata_d;
  logic        rdv_q, rdv_d;

  logic [63:0] uptime;
  logic        wrap;
  logic        wr_ctrl, wr_status, rd_lo, clr;
  logic [3:0]  scr_off;
  logic [31:0] rd_mux;
  logic        scr_sel [NUM_SCRATCH];

  assign wr_ctrl   = write && (address == REG_CTRL);
  assign wr_status = write && (address == REG_STATUS);
  assign rd_lo     = read  && (address == REG_UPTIME_LO);
  assign clr       = wr_ctrl && writedata[CTRL_CLR_BIT];
  assign scr_off   = address - REG_SCRATCH0;

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;

  soc_sysid_uptime #(
    .TICK_DIV (TICK_DIV)
  ) u_uptime (
    .clock    (clock),
    .reset_n  (reset_n),
    .en_i     (ctrl_en_q),
    .clr_i    (clr),
    .uptime_o (uptime),
    .wrap_o   (wrap)
  );

  // Scratch word select: one-hot decode of the implemented scratch slots.
  always_comb begin
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scr_sel[i] = (address >= REG_SCRATCH0) && (scr_off == 4'(i));
    end
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    case (address)
      REG_ID:        rd_mux = SYSTEM_ID;
      REG_TIMESTAMP: rd_mux = TIMESTAMP;
      REG_CAPS:      rd_mux = {CAPS_GEN, 16'(TICK_DIV), 8'(NUM_SCRATCH)};
      REG_CTRL:      rd_mux[CTRL_EN_BIT] = ctrl_en_q;
      REG_STATUS:    rd_mux[STATUS_OVF_BIT] = ovf_q;
      REG_UPTIME_LO: rd_mux = uptime[31:0];
      REG_UPTIME_HI: rd_mux = hi_shadow_q;
      default:       rd_mux = '0;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (scr_sel[i]) rd_mux = scratch_q[i];
    end
  end

  // Register next-state: writes, sticky overflow, shadow capture, read pipe.
  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    ovf_d       = ovf_q;
    hi_shadow_d = hi_shadow_q;
    scratch_d   = scratch_q;
    readdata_d  = readdata_q;
    rdv_d       = read;
    if (wr_ctrl) ctrl_en_d = writedata[CTRL_EN_BIT];
    // A wrap on the same edge as a clear-write keeps the flag set.
    if (wrap) ovf_d = 1'b1;
    else if (wr_status && writedata[STATUS_OVF_BIT]) ovf_d = 1'b0;
    if (rd_lo) hi_shadow_d = uptime[63:32];
    if (read) readdata_d = rd_mux;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (write && scr_sel[i] && byteenable[b]) begin
          scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctrl_en_q   <= 1'b1;
      ovf_q       <= 1'b0;
      hi_shadow_q <= '0;
      readdata_q  <= '0;
      rdv_q       <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      ctrl_en_q   <= ctrl_en_d;
      ovf_q       <= ovf_d;
      hi_shadow_q <= hi_shadow_d;
      readdata_q  <= readdata_d;
      rdv_q       <= rdv_d;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
    end
  end

endmodule

// File: tb/tb_soc_sysid_ext.sv
// Bench for soc_sysid_ext: directed scenarios plus randomized bus traffic,
// all checked against an uptime model expressed as base + enabled_cycles/TICK_DIV.
module tb_soc_sysid_ext;

  localparam int          TD  = 4;
  localparam int          NS  = 4;
  localparam logic [31:0] SID = 32'hC0DE_1234;
  localparam logic [31:0] TS  = 32'd1642576140;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata, readdata_def;
  logic        readdatavalid, readdatavalid_def;

  always #5 clock = ~clock;

  soc_sysid_ext #(
    .SYSTEM_ID(SID), .TIMESTAMP(TS), .NUM_SCRATCH(NS), .TICK_DIV(TD), .ADDR_W(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  soc_sysid_ext dut_def (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata_def),
    .readdatavalid(readdatavalid_def)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [63:0]     m_base;
  longint unsigned m_n;
  logic            m_en, m_ovf, m_rdv;
  logic [31:0]     m_shadow, m_rd;
  logic [31:0]     m_scr [NS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] m_uptime();
    return m_base + 64'(m_n / longint'(TD));
  endfunction

  task automatic m_reset();
    m_base = '0; m_n = 0; m_en = 1'b1; m_ovf = 1'b0; m_rdv = 1'b0;
    m_shadow = '0; m_rd = '0;
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
  endtask

  // One bus edge of the model: reads see pre-edge state, then state updates.
  task automatic m_edge(input logic rd, input logic wr, input logic [3:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    logic [63:0] up, up_next;
    logic [31:0] rv;
    logic        wrapped;
    up = m_uptime();
    wrapped = 1'b0;
    rv = '0;
    case (a)
      4'd0: rv = SID;
      4'd1: rv = TS;
      4'd2: rv = {8'h02, 16'(TD), 8'(NS)};
      4'd3: rv = {31'b0, m_en};
      4'd4: rv = {31'b0, m_ovf};
      4'd5: rv = up[31:0];
      4'd6: rv = m_shadow;
      default: if (a >= 4'd8 && int'(a) < 8 + NS) rv = m_scr[int'(a) - 8];
    endcase
    m_rdv = rd;
    if (rd) m_rd = rv;
    if (rd && a == 4'd5) m_shadow = up[63:32];
    if (wr && a == 4'd3 && wd[1]) begin
      m_base = '0;
      m_n = 0;
    end else if (m_en) begin
      m_n++;
      up_next = m_uptime();
      if (up == '1 && up_next != up) wrapped = 1'b1;
    end
    if (wrapped) m_ovf = 1'b1;
    else if (wr && a == 4'd4 && wd[0]) m_ovf = 1'b0;
    if (wr && a == 4'd3) m_en = wd[0];
    if (wr && a >= 4'd8 && int'(a) < 8 + NS)
      for (int b = 0; b < 4; b++)
        if (be[b]) m_scr[int'(a) - 8][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [3:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    @(posedge clock);
    m_edge(rd, wr, a, wd, be);
    #1;
    chk($sformatf("rdv a%0d", a), {63'b0, readdatavalid}, {63'b0, m_rdv});
    chk($sformatf("rdata a%0d", a), {32'b0, readdata}, {32'b0, m_rd});
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic do_reset(input logic rd);
    reset_n = 1'b0; read = rd; write = 1'b0; address = 4'd0;
    @(posedge clock);
    #1;
    reset_n = 1'b1; read = 1'b0;
    m_reset();
    chk("rst rdv", {63'b0, readdatavalid}, 64'd0);
    chk("rst rdata", {32'b0, readdata}, 64'd0);
  endtask

  // Bench-side preload of the uptime counter, mirrored into the model.
  task automatic preload(input logic [63:0] v);
    force dut.u_uptime.cnt_q = v;
    #1;
    release dut.u_uptime.cnt_q;
    m_base = v - 64'(m_n / longint'(TD));
  endtask

  logic [31:0] def_exp [3];
  logic [31:0] dut_exp [3];

  initial begin
    def_exp[0] = 32'h0000_0000; def_exp[1] = 32'd1642576140; def_exp[2] = 32'h0200_3204;
    dut_exp[0] = SID;           dut_exp[1] = TS;             dut_exp[2] = 32'h0200_0404;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
    m_reset();

    // Identification words, both instances
    do_reset(1'b0);
    for (int a = 0; a < 3; a++) begin
      bus(1'b1, 1'b0, 4'(a), 32'd0, 4'd0);
      chk($sformatf("def word%0d", a), {32'b0, readdata_def}, {32'b0, def_exp[a]});
      chk($sformatf("def rdv%0d", a), {63'b0, readdatavalid_def}, 64'd1);
      chk($sformatf("dut word%0d", a), {32'b0, readdata}, {32'b0, dut_exp[a]});
    end
    idle(1);
    chk("def rdv idle", {63'b0, readdatavalid_def}, 64'd0);

    // 40 enabled cycles at TICK_DIV=4 give 10 ticks; EN=0 then freezes it
    do_reset(1'b0);
    idle(40);
    bus(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);  chk("lo40", {32'b0, readdata}, 64'd10);
    bus(1'b1, 1'b0, 4'd6, 32'd0, 4'd0);  chk("hi40", {32'b0, readdata}, 64'd0);
    bus(1'b0, 1'b1, 4'd3, 32'd0, 4'd0);
    idle(20);
    bus(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);  chk("lo frozen", {32'b0, readdata}, 64'd10);

    // Coherent readout: tick lands on the LO read edge
    bus(1'b0, 1'b1, 4'd3, 32'd3, 4'd0);
    idle(3);
    preload(64'h0000_0000_FFFF_FFFF);
    bus(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);  chk("coh lo", {32'b0, readdata}, 64'hFFFF_FFFF);
    bus(1'b1, 1'b0, 4'd6, 32'd0, 4'd0);  chk("coh hi", {32'b0, readdata}, 64'd0);
    bus(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);  chk("post lo", {32'b0, readdata}, 64'd0);
    bus(1'b1, 1'b0, 4'd6, 32'd0, 4'd0);  chk("post hi", {32'b0, readdata}, 64'd1);

    // 64-bit wrap sets OVF; set beats a same-edge clear; clear later works
    bus(1'b0, 1'b1, 4'd3, 32'd3, 4'd0);
    idle(3);
    preload('1);
    idle(1);
    bus(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);  chk("ovf set", {32'b0, readdata}, 64'd1);
    bus(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);  chk("wrap lo", {32'b0, readdata}, 64'd0);
    bus(1'b1, 1'b0, 4'd6, 32'd0, 4'd0);  chk("wrap hi", {32'b0, readdata}, 64'd0);
    bus(1'b0, 1'b1, 4'd3, 32'd3, 4'd0);
    bus(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);  chk("ovf after clr", {32'b0, readdata}, 64'd1);
    idle(2);
    preload('1);
    bus(1'b0, 1'b1, 4'd4, 32'd1, 4'd0);
    bus(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);  chk("ovf set wins", {32'b0, readdata}, 64'd1);
    bus(1'b0, 1'b1, 4'd4, 32'd1, 4'd0);
    bus(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);  chk("ovf cleared", {32'b0, readdata}, 64'd0);

    // Scratch byte lanes, read-only words, unmapped words
    bus(1'b0, 1'b1, 4'd8, 32'hA5A5_A5A5, 4'b1111);
    bus(1'b0, 1'b1, 4'd8, 32'h1234_5678, 4'b0101);
    bus(1'b1, 1'b0, 4'd8, 32'd0, 4'd0);  chk("scr0 be", {32'b0, readdata}, 64'hA534_A578);
    bus(1'b0, 1'b1, 4'd11, 32'hDEAD_BEEF, 4'b1010);
    bus(1'b1, 1'b0, 4'd11, 32'd0, 4'd0); chk("scr3 be", {32'b0, readdata}, 64'hDE00_BE00);
    bus(1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF, 4'b1111);
    bus(1'b1, 1'b0, 4'd0, 32'd0, 4'd0);  chk("id ro", {32'b0, readdata}, {32'b0, SID});
    bus(1'b0, 1'b1, 4'd12, 32'h5555_5555, 4'b1111);
    bus(1'b1, 1'b0, 4'd12, 32'd0, 4'd0); chk("word12", {32'b0, readdata}, 64'd0);
    bus(1'b1, 1'b0, 4'd15, 32'd0, 4'd0); chk("word15", {32'b0, readdata}, 64'd0);
    bus(1'b1, 1'b1, 4'd8, 32'h0F0F_0F0F, 4'b1111);
    chk("rw same", {32'b0, readdata}, 64'hA534_A578);

    // CLR on a tick edge: no increment, prescaler restarts
    bus(1'b0, 1'b1, 4'd3, 32'd3, 4'd0);
    idle(6);
    bus(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);  chk("pre clr lo", {32'b0, readdata}, 64'd1);
    bus(1'b0, 1'b1, 4'd3, 32'd3, 4'd0);
    bus(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);  chk("clr lo", {32'b0, readdata}, 64'd0);
    idle(2);
    bus(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);  chk("clr lo3", {32'b0, readdata}, 64'd0);
    bus(1'b1, 1'b0, 4'd5, 32'd0, 4'd0);  chk("clr lo4", {32'b0, readdata}, 64'd1);
    bus(1'b1, 1'b0, 4'd3, 32'd0, 4'd0);  chk("ctrl rd", {32'b0, readdata}, 64'd1);

    // Reset with a read in flight
    bus(1'b0, 1'b1, 4'd3, 32'd0, 4'd0);
    bus(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
    do_reset(1'b1);
    bus(1'b1, 1'b0, 4'd3, 32'd0, 4'd0);  chk("rst ctrl", {32'b0, readdata}, 64'd1);
    bus(1'b1, 1'b0, 4'd8, 32'd0, 4'd0);  chk("rst scr0", {32'b0, readdata}, 64'd0);
    bus(1'b1, 1'b0, 4'd6, 32'd0, 4'd0);  chk("rst hi", {32'b0, readdata}, 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 75) preload({32'hFFFF_FFFF, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))});
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
      else bus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
